stage_ctrl: RTL

STAGE_CTRL -- requirements
Module: stage_ctrl

---
 rtl/stage_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/stage_ctrl.sv
// stage_ctrl: per-stage player controller for a small room-crawler game.
// The player moves STEP pixels per accepted tick. After each move, the
// controller checks five objects against the player position, one per cycle:
// key0, key1, key2, light and door.
// Collecting all three keys and then touching the door clears the stage.
// Optional feature macro: DARK_STAGE_EN. When it is defined, stage 2 starts
// dark, and keys in that stage cannot be collected until the light is touched.
// When it is undefined, is_dark is tied low and the light check slot idles.
module stage_ctrl #(
    parameter int STEP  = 2,
    parameter int HIT   = 16,
    parameter int X_MAX = 304,
    parameter int Y_MAX = 224
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] stage,
    input  logic       start,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [1:0] key_find,
    output logic [2:0] key_mask,
    output logic       is_dark,
    output logic       pass,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_MOVE = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // 10-bit copies of the parameters. Move and distance arithmetic is done
    // one bit wider than the 9-bit position, so sums cannot wrap.
    localparam logic [9:0] STEP_W  = 10'(STEP);
    localparam logic [9:0] HIT_W   = 10'(HIT);
    localparam logic [9:0] X_MAX_W = 10'(X_MAX);
    localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);

    localparam logic [8:0] START_X = 9'd40;
    localparam logic [8:0] START_Y = 9'd130;

    state_t     state_q, state_d;
    logic [2:0] chk_idx_q, chk_idx_d;
    logic [1:0] stage_q;
    logic [1:0] dir_q;

    logic       start_ok;
    logic       run_go;
    logic       do_init;
    logic       do_move;
    logic       key_take;
    logic       pass_d;
`ifdef DARK_STAGE_EN
    logic       light_clr;
`endif

    logic [8:0] obj_x, obj_y;
    logic [9:0] dx, dy;
    logic       hit;
    logic [9:0] nx, ny;

    // A start pulse with stage 0 is treated as noise and is ignored.
    assign start_ok = start && (stage != 2'd0);

    // Busy covers the whole move/check sequence plus the INIT cycle.
    assign busy = (state_q == S_INIT) || (state_q == S_MOVE) || (state_q == S_CHK);

    // Position of the object checked in the current CHK slot.
    always_comb begin
        obj_x = 9'd0;
        obj_y = 9'd0;
        case (chk_idx_q)
            3'd3: begin obj_x = 9'd150; obj_y = 9'd120; end   // light
            3'd4: begin obj_x = 9'd288; obj_y = 9'd120; end   // door
            default: begin
                case ({stage_q, chk_idx_q[1:0]})
                    4'b01_00: begin obj_x = 9'd100; obj_y = 9'd40;  end
                    4'b01_01: begin obj_x = 9'd200; obj_y = 9'd180; end
                    4'b01_10: begin obj_x = 9'd280; obj_y = 9'd60;  end
                    4'b10_00: begin obj_x = 9'd60;  obj_y = 9'd200; end
                    4'b10_01: begin obj_x = 9'd160; obj_y = 9'd40;  end
                    4'b10_10: begin obj_x = 9'd260; obj_y = 9'd200; end
                    4'b11_00: begin obj_x = 9'd40;  obj_y = 9'd40;  end
                    4'b11_01: begin obj_x = 9'd280; obj_y = 9'd40;  end
                    4'b11_10: begin obj_x = 9'd160; obj_y = 9'd200; end
                    default:  begin obj_x = 9'd0;   obj_y = 9'd0;   end
                endcase
            end
        endcase
    end

    // Strict collision window on both axes; a distance of exactly HIT misses.
    always_comb begin
        dx  = (player_x >= obj_x) ? ({1'b0, player_x} - {1'b0, obj_x})
                                  : ({1'b0, obj_x} - {1'b0, player_x});
        dy  = (player_y >= obj_y) ? ({1'b0, player_y} - {1'b0, obj_y})
                                  : ({1'b0, obj_y} - {1'b0, player_y});
        hit = (dx < HIT_W) && (dy < HIT_W);
    end

    // Saturating next position for the latched direction.
    always_comb begin
        nx = {1'b0, player_x};
        ny = {1'b0, player_y};
        case (dir_q)
            2'd0: ny = (ny < STEP_W) ? 10'd0 : ny - STEP_W;
            2'd1: nx = (nx < STEP_W) ? 10'd0 : nx - STEP_W;
            2'd2: ny = (ny + STEP_W > Y_MAX_W) ? Y_MAX_W : ny + STEP_W;
            default: nx = (nx + STEP_W > X_MAX_W) ? X_MAX_W : nx + STEP_W;
        endcase
    end

    // State register and check-slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chk_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            chk_idx_q <= chk_idx_d;
        end
    end

    // Next-state logic and datapath strobes; start preempts everything.
    always_comb begin
        state_d   = state_q;
        chk_idx_d = chk_idx_q;
        run_go    = 1'b0;
        do_init   = 1'b0;
        do_move   = 1'b0;
        key_take  = 1'b0;
        pass_d    = 1'b0;
`ifdef DARK_STAGE_EN
        light_clr = 1'b0;
`endif
        if (start_ok) begin
            state_d   = S_INIT;
            chk_idx_d = 3'd0;
            do_init   = 1'b1;
        end else begin
            case (state_q)
                S_INIT: state_d = S_RUN;
                S_RUN: begin
                    if (tick && dir_valid) begin
                        run_go  = 1'b1;
                        state_d = S_MOVE;
                    end
                end
                S_MOVE: begin
                    do_move   = 1'b1;
                    chk_idx_d = 3'd0;
                    state_d   = S_CHK;
                end
                S_CHK: begin
                    chk_idx_d = chk_idx_q + 3'd1;
                    case (chk_idx_q)
                        3'd0, 3'd1, 3'd2:
                            key_take = hit && !key_mask[chk_idx_q[1:0]] && !is_dark;
                        3'd3: begin
`ifdef DARK_STAGE_EN
                            light_clr = hit;
`endif
                        end
                        default: begin
                            chk_idx_d = 3'd0;
                            if (hit && (key_find == 2'd3) && !is_dark) begin
                                state_d = S_DONE;
                                pass_d  = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
                default: ;  // IDLE and DONE wait for start
            endcase
        end
    end

    // Player position, key bookkeeping and the stage-cleared pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            player_x <= START_X;
            player_y <= START_Y;
            key_find <= 2'd0;
            key_mask <= 3'd0;
            pass     <= 1'b0;
            stage_q  <= 2'd1;
            dir_q    <= 2'd0;
        end else begin
            pass <= pass_d;
            if (run_go)
                dir_q <= dir;
            if (do_init) begin
                stage_q  <= stage;
                player_x <= START_X;
                player_y <= START_Y;
                key_find <= 2'd0;
                key_mask <= 3'd0;
            end else begin
                if (do_move) begin
                    player_x <= nx[8:0];
                    player_y <= ny[8:0];
                end
                if (key_take) begin
                    key_mask[chk_idx_q[1:0]] <= 1'b1;
                    key_find <= (key_find == 2'd3) ? 2'd3 : key_find + 2'd1;
                end
            end
        end
    end

`ifdef DARK_STAGE_EN
    // Stage 2 starts dark; touching the light turns it on for the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            is_dark <= 1'b0;
        else if (do_init)
            is_dark <= (stage == 2'd2);
        else if (light_clr)
            is_dark <= 1'b0;
    end
`else
    assign is_dark = 1'b0;
`endif

endmodule
